oled_pattern_streamer: RTL and testbench

- Parametrised test-pattern source that streams RGB565 pixels with (x, y) coordinates into the SSD1331 OLED driver's pixel port over a strobe/ready handshake.
- Replaces the free-running always-strobe pattern generator.
- Adds selectable pattern modes, frame accounting, an inter-frame gap and an enable control, so firmware or test logic can drive the panel deterministically.

---
 rtl/oled_pkg.sv | 33 +++
 rtl/oled_pattern_color.sv | 35 +++
 rtl/oled_pattern_streamer.sv | 181 ++++++++++++++++++
 tb/tb_oled_pattern_streamer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared types and RGB565 constants for the OLED test-pattern streamer.
package oled_pkg;

  typedef enum logic [2:0] {
    MODE_SOLID    = 3'd0,
    MODE_BARS     = 3'd1,
    MODE_CHECKER  = 3'd2,
    MODE_GRADIENT = 3'd3,
    MODE_SCROLL   = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_GAP
  } state_e;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  localparam logic [15:0] BAR_PAL [8] = '{
    RGB_WHITE, RGB_YELLOW, RGB_CYAN, RGB_GREEN,
    RGB_MAGENTA, RGB_RED, RGB_BLUE, RGB_BLACK
  };

endpackage

// File: rtl/oled_pattern_color.sv
// Combinational colour lookup for one pixel of the selected pattern.
module oled_pattern_color
  import oled_pkg::*;
#(
  parameter int XW        = 7,
  parameter int YW        = 6,
  parameter int CHK_SHIFT = 3,
  parameter int FCW       = 16
) (
  input  logic [XW-1:0]  x,
  input  logic [YW-1:0]  y,
  input  logic [2:0]     mode_q,
  input  logic [15:0]    solid_q,
  input  logic [FCW-1:0] frame_cnt,
  input  logic [2:0]     bar,
  input  logic [2:0]     bar_s,
  output logic [15:0]    color
);

  logic chk;

  always_comb begin
    chk   = 1'(x >> CHK_SHIFT) ^ 1'(y >> CHK_SHIFT);
    color = RGB_BLACK;
    case (mode_q)
      MODE_SOLID:    color = solid_q;
      MODE_BARS:     color = BAR_PAL[bar];
      MODE_CHECKER:  color = chk ? RGB_WHITE : RGB_BLACK;
      MODE_GRADIENT: color = {5'(x >> 2), 6'(y), 5'(frame_cnt)};
      MODE_SCROLL:   color = BAR_PAL[bar_s];
      default:       color = RGB_BLACK;
    endcase
  end

endmodule

// File: rtl/oled_pattern_streamer.sv
// Test-pattern pixel source feeding the SSD1331 driver over strobe/ready.
module oled_pattern_streamer
  import oled_pkg::*;
#(
  parameter int WIDTH      = 96,
  parameter int HEIGHT     = 64,
  parameter int XW         = $clog2(WIDTH),
  parameter int YW         = $clog2(HEIGHT),
  parameter int CHK_SHIFT  = 3,
  parameter int GAP_CYCLES = 16,
  parameter int FCW        = 16
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           enable,
  input  logic [2:0]     mode,
  input  logic [15:0]    solid_rgb,
  output logic           strobe,
  input  logic           ready,
  output logic [XW-1:0]  x,
  output logic [YW-1:0]  y,
  output logic [15:0]    rgb,
  output logic           frame_start,
  output logic           frame_done,
  output logic [FCW-1:0] frame_cnt,
  output logic           busy
);

  localparam int BW = (WIDTH / 8 > 1) ? WIDTH / 8 : 1;
  localparam int SW = (BW > 1) ? $clog2(BW) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);
  localparam logic [SW-1:0] SUB_LAST = SW'(BW - 1);
  localparam logic [GW-1:0] GAP_LAST =
    (GAP_CYCLES > 1) ? GW'(GAP_CYCLES - 1) : '0;

  // Bar index advances every BW columns and saturates at the last bar.
  function automatic logic [SW+2:0] bar_step(
    input logic [2:0]    b,
    input logic [SW-1:0] s
  );
    if (s != SUB_LAST) return {b, s + SW'(1)};
    if (b != 3'd7) return {b + 3'd1, SW'(0)};
    return {b, s};
  endfunction

  state_e        state;
  logic [2:0]    mode_q;
  logic [15:0]   solid_q;
  logic [2:0]    bar_x, bar_s, sc_bar;
  logic [SW-1:0] sub_x, sub_s, sc_sub;
  logic [XW-1:0] xs, sc_x;
  logic [GW-1:0] gap_cnt;

  logic          x_end, xs_end, last_px, acc, adv;
  logic [XW-1:0] nx, nxs;
  logic [YW-1:0] ny;
  logic [2:0]    nbx, nbs, c_mode;
  logic [SW-1:0] nsx, nss;
  logic [15:0]   c_solid, c_rgb;

  always_comb begin
    x_end   = (x == X_LAST);
    xs_end  = (xs == X_LAST);
    last_px = x_end && (y == Y_LAST);
    acc     = strobe && ready;
    adv     = (state == ST_LOAD) ||
              (state == ST_STREAM && acc && !last_px);
    c_mode  = mode_q;
    c_solid = solid_q;
    nx      = x_end ? '0 : x + XW'(1);
    ny      = x_end ? y + YW'(1) : y;
    {nbx, nsx} = x_end ? '0 : bar_step(bar_x, sub_x);
    nxs     = xs_end ? '0 : xs + XW'(1);
    {nbs, nss} = xs_end ? '0 : bar_step(bar_s, sub_s);
    if (state == ST_LOAD) begin
      c_mode     = mode;
      c_solid    = solid_rgb;
      nx         = '0;
      ny         = '0;
      {nbx, nsx} = '0;
      nxs        = sc_x;
      nbs        = sc_bar;
      nss        = sc_sub;
    end
  end

  oled_pattern_color #(
    .XW(XW), .YW(YW), .CHK_SHIFT(CHK_SHIFT), .FCW(FCW)
  ) u_color (
    .x         (nx),
    .y         (ny),
    .mode_q    (c_mode),
    .solid_q   (c_solid),
    .frame_cnt (frame_cnt),
    .bar       (nbx),
    .bar_s     (nbs),
    .color     (c_rgb)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      strobe      <= 1'b0;
      x           <= '0;
      y           <= '0;
      rgb         <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
      busy        <= 1'b0;
      mode_q      <= '0;
      solid_q     <= '0;
      bar_x       <= '0;
      sub_x       <= '0;
      xs          <= '0;
      bar_s       <= '0;
      sub_s       <= '0;
      sc_x        <= '0;
      sc_bar      <= '0;
      sc_sub      <= '0;
      gap_cnt     <= '0;
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      if (adv) begin
        x     <= nx;
        y     <= ny;
        rgb   <= c_rgb;
        bar_x <= nbx;
        sub_x <= nsx;
        xs    <= nxs;
        bar_s <= nbs;
        sub_s <= nss;
      end
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (enable) state <= ST_LOAD;
        end
        ST_LOAD: begin
          mode_q      <= c_mode;
          solid_q     <= c_solid;
          strobe      <= 1'b1;
          frame_start <= 1'b1;
          busy        <= 1'b1;
          state       <= ST_STREAM;
        end
        ST_STREAM: begin
          if (acc && last_px) begin
            strobe     <= 1'b0;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + FCW'(1);
            gap_cnt    <= '0;
            state      <= ST_GAP;
            // Scroll offset tracks frame_cnt mod WIDTH, including its wrap.
            if (frame_cnt == '1 || sc_x == X_LAST) begin
              sc_x   <= '0;
              sc_bar <= '0;
              sc_sub <= '0;
            end else begin
              sc_x             <= sc_x + XW'(1);
              {sc_bar, sc_sub} <= bar_step(sc_bar, sc_sub);
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= enable ? ST_LOAD : ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_pattern_streamer.sv
// Directed bench for oled_pattern_streamer with hand-computed pixels.
module tb_oled_pattern_streamer;

  localparam int XW   = 7;
  localparam int YW   = 6;
  localparam int NPIX = 96 * 64;

  logic          clk = 1'b0;
  logic          resetn, enable, ready;
  logic [2:0]    mode;
  logic [15:0]   solid_rgb;
  logic          strobe, frame_start, frame_done, busy;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [15:0]   rgb;
  logic [15:0]   frame_cnt;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  int n_acc, order_err, stab_err, fs_cnt, lead_low, lead_busy, bad;
  bit fs_first, fd_seen;
  logic [15:0] pix [NPIX];

  always #5 clk = ~clk;

  oled_pattern_streamer dut (
    .clk         (clk),
    .resetn      (resetn),
    .enable      (enable),
    .mode        (mode),
    .solid_rgb   (solid_rgb),
    .strobe      (strobe),
    .ready       (ready),
    .x           (x),
    .y           (y),
    .rgb         (rgb),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic stream_frame(input bit rnd, input int drop_at,
                              input int sw_at, input logic [2:0] sw_mode);
    bit hold, first;
    logic [XW-1:0] hx;
    logic [YW-1:0] hy;
    logic [15:0]   hrgb;
    n_acc = 0; order_err = 0; stab_err = 0; fs_cnt = 0;
    lead_low = 0; lead_busy = 0; fs_first = 0; fd_seen = 0;
    hold = 0; first = 0; hx = '0; hy = '0; hrgb = '0;
    for (int c = 0; c < 30000; c++) begin
      @(negedge clk);
      if (frame_done) begin
        fd_seen = 1;
        break;
      end
      if (frame_start) fs_cnt++;
      if (!first && !strobe) begin
        lead_low++;
        if (busy) lead_busy++;
      end
      if (!first && strobe) begin
        first = 1;
        fs_first = frame_start;
      end
      if (hold && (!strobe || x !== hx || y !== hy || rgb !== hrgb))
        stab_err++;
      ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (strobe && ready) begin
        if (int'(x) != n_acc % 96 || int'(y) != n_acc / 96) order_err++;
        if (n_acc < NPIX) pix[n_acc] = rgb;
        n_acc++;
        if (n_acc == drop_at) enable = 1'b0;
        if (n_acc == sw_at) mode = sw_mode;
      end
      hold = strobe && !ready;
      hx = x; hy = y; hrgb = rgb;
    end
  endtask

  initial begin
    int cnt;
    resetn = 0; enable = 0; mode = 0; solid_rgb = 0; ready = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {strobe, x, y, rgb, frame_start, frame_done, frame_cnt, busy}, 0);
    resetn = 1;

    // Frame 1: bars, always ready
    enable = 1; mode = 3'd1;
    stream_frame(0, -1, -1, 3'd0);
    chk("f1_done", fd_seen, 1);
    chk("f1_fs_first", fs_first, 1);
    chk("f1_fs_cnt", fs_cnt, 1);
    chk("f1_count", n_acc, NPIX);
    chk("f1_order", order_err, 0);
    chk("f1_px_0_0", pix[0], 16'hFFFF);
    chk("f1_px_12_0", pix[12], 16'hFFE0);
    chk("f1_px_83_0", pix[83], 16'h001F);
    chk("f1_px_84_0", pix[84], 16'h0000);
    chk("f1_px_24_63", pix[63*96+24], 16'h07FF);
    chk("f1_px_95_63", pix[NPIX-1], 16'h0000);
    chk("f1_frame_cnt", frame_cnt, 1);
    chk("f1_strobe_low", strobe, 0);

    // Frame 2: checker, random ready
    mode = 3'd2;
    stream_frame(1, -1, -1, 3'd0);
    chk("f2_gap_low", lead_low, 16);
    chk("f2_gap_busy", lead_busy, 15);
    chk("f2_count", n_acc, NPIX);
    chk("f2_order", order_err, 0);
    chk("f2_stable", stab_err, 0);
    chk("f2_px_0_0", pix[0], 16'h0000);
    chk("f2_px_7_0", pix[7], 16'h0000);
    chk("f2_px_8_0", pix[8], 16'hFFFF);
    chk("f2_px_16_0", pix[16], 16'h0000);
    chk("f2_px_8_8", pix[8*96+8], 16'h0000);
    chk("f2_frame_cnt", frame_cnt, 2);

    // Frame 3: solid, mode changed mid-frame; frame 4 checker
    mode = 3'd0; solid_rgb = 16'hF800;
    stream_frame(0, -1, 50, 3'd2);
    bad = 0;
    for (int i = 0; i < NPIX; i++) if (pix[i] !== 16'hF800) bad++;
    chk("f3_count", n_acc, NPIX);
    chk("f3_solid_bad", bad, 0);
    stream_frame(0, -1, -1, 3'd0);
    chk("f4_px_8_0", pix[8], 16'hFFFF);
    chk("f4_px_0_8", pix[8*96], 16'hFFFF);
    chk("f4_px_9_9", pix[9*96+9], 16'h0000);
    chk("f4_px_8_16", pix[16*96+8], 16'hFFFF);
    chk("f4_frame_cnt", frame_cnt, 4);

    // Frames 5-7: scroll with offset 4, 5, 6
    mode = 3'd4;
    stream_frame(0, -1, -1, 3'd0);
    chk("s4_px_7", pix[7], 16'hFFFF);
    chk("s4_px_8", pix[8], 16'hFFE0);
    chk("s4_px_91", pix[91], 16'h0000);
    chk("s4_px_92", pix[92], 16'hFFFF);
    chk("s4_px_8_1", pix[96+8], 16'hFFE0);
    stream_frame(0, -1, -1, 3'd0);
    chk("s5_px_6", pix[6], 16'hFFFF);
    chk("s5_px_7", pix[7], 16'hFFE0);
    chk("s5_px_90", pix[90], 16'h0000);
    chk("s5_px_91", pix[91], 16'hFFFF);
    stream_frame(0, -1, -1, 3'd0);
    chk("s6_px_6", pix[6], 16'hFFE0);
    chk("s6_px_89", pix[89], 16'h0000);
    chk("s6_px_90", pix[90], 16'hFFFF);
    chk("s6_frame_cnt", frame_cnt, 7);

    // Frame 8: enable dropped at pixel 100
    stream_frame(0, 100, -1, 3'd0);
    chk("f8_done", fd_seen, 1);
    chk("f8_count", n_acc, NPIX);
    chk("f8_px_5", pix[5], 16'hFFE0);
    chk("f8_frame_cnt", frame_cnt, 8);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (strobe) cnt++;
    end
    chk("idle_no_strobe", cnt, 0);
    chk("idle_busy", busy, 0);

    // Mid-frame reset, then gradient frames
    mode = 3'd3; enable = 1;
    cnt = 0; bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      ready = 1'b1;
      if (frame_done) bad++;
      if (strobe) cnt++;
      if (cnt == 200) break;
    end
    chk("pre_reset_accepts", cnt, 200);
    resetn = 0;
    @(negedge clk);
    chk("midreset_outputs",
        {strobe, x, y, rgb, frame_start, frame_done, frame_cnt, busy}, 0);
    chk("midreset_no_done", bad, 0);
    resetn = 1;
    stream_frame(0, -1, -1, 3'd0);
    chk("g0_fs_first", fs_first, 1);
    chk("g0_count", n_acc, NPIX);
    chk("g0_order", order_err, 0);
    chk("g0_px_0_0", pix[0], 16'h0000);
    chk("g0_px_4_1", pix[100], 16'h0820);
    chk("g0_px_95_63", pix[NPIX-1], 16'hBFE0);
    chk("g0_frame_cnt", frame_cnt, 1);
    stream_frame(0, -1, -1, 3'd0);
    chk("g1_px_0_0", pix[0], 16'h0001);
    chk("g1_px_95_63", pix[NPIX-1], 16'hBFE1);
    chk("g1_frame_cnt", frame_cnt, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
